prince_twocycle_cipher: RTL and testbench

- Iterative PRINCE-64 block-cipher encryption core with a 128-bit key.
- Pass 1 (one clock): pre-whitening, five forward rounds and the middle layer (S, M', S^-1). The result is stored in a 64-bit half-state register.
- Pass 2 (one clock): five inverse rounds and post-whitening, then the ciphertext is registered.
- Sits as the encryption engine behind a bus/stream wrapper that supplies plaintext and key with a start pulse.

---
 rtl/prince_twocycle_cipher_if.sv | 12 +
 rtl/prince_twocycle_cipher.sv | 116 +++++++++++
 tb/tb_prince_twocycle_cipher.sv | 129 ++++++++++++
 3 files changed

// File: rtl/prince_twocycle_cipher_if.sv
// Start/data/result bundle between a stream or bus wrapper and the PRINCE engine.
interface prince_twocycle_cipher_if;
  logic         start;
  logic [63:0]  plaintext;
  logic [127:0] key;
  logic         busy;
  logic         done;
  logic [63:0]  ciphertext;

  modport master (output start, plaintext, key, input busy, done, ciphertext);
  modport slave  (input start, plaintext, key, output busy, done, ciphertext);
endinterface

// File: rtl/prince_twocycle_cipher.sv
// PRINCE-64 encryption in two clocks: forward half and middle layer, then inverse half.
// Nibble 0 is the most significant nibble throughout.
module prince_twocycle_cipher (
  input logic                     clk,
  input logic                     rst,
  prince_twocycle_cipher_if.slave bus
);

  // Lookup tables are packed with entry 15 at the top so entry v sits at bits 4v+3:4v
  localparam logic [63:0] SBOX  = 64'h4d5e087619ca23fb;
  localparam logic [63:0] SBOXI = 64'h1ce5046a98df237b;

  localparam logic [11:0][63:0] RC = {
    64'hc0ac29b7c97c50dd, 64'hd3b5a399ca0c2399, 64'h64a51195e0e3610d,
    64'hc882d32f25323c54, 64'h85840851f1ac43aa, 64'h7ef84f78fd955cb1,
    64'hbe5466cf34e90c6c, 64'h452821e638d01377, 64'h082efa98ec4e6c89,
    64'ha4093822299f31d0, 64'h13198a2e03707344, 64'h0000000000000000};

  typedef enum logic {IDLE, PASS2} state_t;

  function automatic logic [63:0] sub(input logic [63:0] x, input logic [63:0] tbl);
    logic [63:0] y;
    y = '0;
    for (int i = 0; i < 16; i++) y[4*i +: 4] = tbl[{x[4*i +: 4], 2'b00} +: 4];
    return y;
  endfunction

  // Each output bit is the XOR of the same bit position in three of the four
  // nibbles of its 16-bit chunk; which nibble drops out rotates per row.
  function automatic logic [63:0] mprime(input logic [63:0] x);
    logic [63:0] y;
    logic [3:0]  o;
    int          h;
    y = '0;
    for (int c = 0; c < 4; c++) begin
      h = (c == 1 || c == 2) ? 1 : 0;
      for (int j = 0; j < 4; j++) begin
        o = '0;
        for (int k = 0; k < 4; k++)
          o = o ^ (x[60-16*c-4*k +: 4] & ~(4'b1000 >> ((j + h + k) % 4)));
        y[60-16*c-4*j +: 4] = o;
      end
    end
    return y;
  endfunction

  // Shift-rows permutation is i -> 5i mod 16 on nibble indices
  function automatic logic [63:0] sr(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int i = 0; i < 16; i++) y[60-4*i +: 4] = x[60-4*((5*i)%16) +: 4];
    return y;
  endfunction

  function automatic logic [63:0] srinv(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int i = 0; i < 16; i++) y[60-4*((5*i)%16) +: 4] = x[60-4*i +: 4];
    return y;
  endfunction

  state_t      state;
  logic        busy_q, done_q;
  logic [63:0] ct_q, hs, k1_q, k0p_q;
  logic [63:0] k0, k1, k0p, s1, s2;

  assign k0  = bus.key[127:64];
  assign k1  = bus.key[63:0];
  assign k0p = {k0[0], k0[63:1]} ^ {63'b0, k0[63]};

  always_comb begin
    s1 = bus.plaintext ^ k0 ^ k1 ^ RC[0];
    for (int i = 1; i <= 5; i++) s1 = sr(mprime(sub(s1, SBOX))) ^ RC[i] ^ k1;
    s1 = sub(mprime(sub(s1, SBOX)), SBOXI);
  end

  always_comb begin
    s2 = hs;
    for (int i = 6; i <= 10; i++) s2 = sub(mprime(srinv(s2 ^ k1_q ^ RC[i])), SBOXI);
    s2 = s2 ^ RC[11] ^ k1_q ^ k0p_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      ct_q   <= '0;
      hs     <= '0;
      k1_q   <= '0;
      k0p_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          hs     <= s1;
          k1_q   <= k1;
          k0p_q  <= k0p;
          busy_q <= 1'b1;
          state  <= PASS2;
        end
        PASS2: begin
          ct_q   <= s2;
          done_q <= 1'b1;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.ciphertext = ct_q;

endmodule

// File: tb/tb_prince_twocycle_cipher.sv
// Directed-vector bench for the two-cycle PRINCE core: known-answer vectors and control corners.
module tb_prince_twocycle_cipher;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  prince_twocycle_cipher_if bus ();

  prince_twocycle_cipher dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  logic [63:0]  vpt  [5] = '{64'h0, 64'hffffffffffffffff, 64'h0, 64'h0, 64'h0123456789abcdef};
  logic [127:0] vkey [5] = '{128'h0, 128'h0,
                             {64'hffffffffffffffff, 64'h0},
                             {64'h0, 64'hffffffffffffffff},
                             {64'h0, 64'hfedcba9876543210}};
  logic [63:0]  vexp [5] = '{64'h818665aa0d02dfda, 64'h604ae6ca03c20ada, 64'h9fb51935fc3df524,
                             64'h78a54cbe737bb7ef, 64'hae25ad3ca8fa9ccf};

  task automatic test_reset();
    bus.start = 1'b0; bus.plaintext = '0; bus.key = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", bus.done); end
    checks++; if (bus.ciphertext !== 64'h0) begin errors++; $display("FAIL reset_ct got %h want 0", bus.ciphertext); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_vectors();
    for (int v = 0; v < 5; v++) begin
      bus.start = 1'b1; bus.plaintext = vpt[v]; bus.key = vkey[v];
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL vec%0d_idle busy=%b want 0", v, bus.busy); end
      @(negedge clk);
      bus.start = 1'b0;
      checks++; if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
        errors++; $display("FAIL vec%0d_pass2 busy=%b done=%b want 1/0", v, bus.busy, bus.done); end
      @(negedge clk);
      checks++; if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
        errors++; $display("FAIL vec%0d_done done=%b busy=%b want 1/0", v, bus.done, bus.busy); end
      checks++; if (bus.ciphertext !== vexp[v]) begin
        errors++; $display("FAIL vec%0d_ct got %h want %h", v, bus.ciphertext, vexp[v]); end
      @(negedge clk);
      checks++; if (bus.done !== 1'b0 || bus.ciphertext !== vexp[v]) begin
        errors++; $display("FAIL vec%0d_hold done=%b ct=%h want 0/%h", v, bus.done, bus.ciphertext, vexp[v]); end
    end
  endtask

  task automatic test_back_to_back();
    bus.start = 1'b1; bus.plaintext = vpt[0]; bus.key = vkey[0];
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    checks++; if (bus.done !== 1'b1 || bus.ciphertext !== vexp[0]) begin
      errors++; $display("FAIL b2b_first done=%b ct=%h want 1/%h", bus.done, bus.ciphertext, vexp[0]); end
    bus.start = 1'b1; bus.plaintext = vpt[2]; bus.key = vkey[2];
    @(negedge clk);
    bus.start = 1'b0;
    checks++; if (bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.ciphertext !== vexp[0]) begin
      errors++; $display("FAIL b2b_mid busy=%b done=%b ct=%h want 1/0/%h", bus.busy, bus.done, bus.ciphertext, vexp[0]); end
    @(negedge clk);
    checks++; if (bus.done !== 1'b1 || bus.ciphertext !== vexp[2]) begin
      errors++; $display("FAIL b2b_second done=%b ct=%h want 1/%h", bus.done, bus.ciphertext, vexp[2]); end
    @(negedge clk);
  endtask

  task automatic test_start_busy();
    int ndone;
    ndone = 0;
    bus.start = 1'b1; bus.plaintext = vpt[1]; bus.key = vkey[1];
    @(negedge clk);
    // keep start high with different data while busy; it must be ignored
    bus.plaintext = vpt[3]; bus.key = vkey[3];
    @(negedge clk);
    bus.start = 1'b0;
    checks++; if (bus.done !== 1'b1 || bus.ciphertext !== vexp[1]) begin
      errors++; $display("FAIL busy_ignore done=%b ct=%h want 1/%h", bus.done, bus.ciphertext, vexp[1]); end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (bus.done === 1'b1) ndone++;
    end
    checks++; if (ndone !== 0) begin errors++; $display("FAIL busy_extra_done got %0d want 0", ndone); end
    checks++; if (bus.ciphertext !== vexp[1]) begin
      errors++; $display("FAIL busy_ct_hold got %h want %h", bus.ciphertext, vexp[1]); end
  endtask

  task automatic test_reset_mid();
    int ndone;
    ndone = 0;
    bus.start = 1'b1; bus.plaintext = vpt[4]; bus.key = vkey[4];
    @(negedge clk);
    bus.start = 1'b0;
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL rstmid_busy got %b want 1", bus.busy); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL rstmid_ctrl done=%b busy=%b want 0/0", bus.done, bus.busy); end
    checks++; if (bus.ciphertext !== 64'h0) begin
      errors++; $display("FAIL rstmid_ct got %h want 0", bus.ciphertext); end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (bus.done === 1'b1) ndone++;
    end
    checks++; if (ndone !== 0) begin errors++; $display("FAIL rstmid_late_done got %0d want 0", ndone); end
    // core must still work after the aborted block
    bus.start = 1'b1; bus.plaintext = vpt[3]; bus.key = vkey[3];
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    checks++; if (bus.done !== 1'b1 || bus.ciphertext !== vexp[3]) begin
      errors++; $display("FAIL rstmid_recover done=%b ct=%h want 1/%h", bus.done, bus.ciphertext, vexp[3]); end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_back_to_back();
    test_start_busy();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
